// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential 64-bit multiplier.
// The datapath width is tied to the shared 64-bit adder and is not meant to change.
package mul_pkg;

    localparam int MUL_WIDTH = 64;
    localparam int CNT_WIDTH = 6;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/add64.sv
// Shared 64-bit adder, combinational: ctrl[0] subtracts b, ctrl[1] forces carry-in.
// ovf is signed overflow of the selected operation; carry out of bit 63 is dropped.
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  ctrl,
    output logic [63:0] sum,
    output logic        ovf
);

    logic [63:0] b_op;
    logic        cin;

    always_comb begin
        b_op = ctrl[0] ? ~b : b;
        cin  = ctrl[0] | ctrl[1];
        sum  = a + b_op + {63'd0, cin};
        ovf  = (a[63] == b_op[63]) && (sum[63] != a[63]);
    end

endmodule

// File: rtl/mul64_seq.sv
// Shift-and-add multiplier: one multiplier bit per RUN cycle, product is (a*b) mod 2^64.
// start is accepted only in IDLE with no queuing; flush cancels any operation on the next edge.
module mul64_seq
    import mul_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1,
    parameter int WIDTH      = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    mul_state_e           state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_ovf_unused;
    logic                 last_step;

    add64 u_add (
        .a    (acc_q),
        .b    (mcand_q),
        .ctrl (2'b00),
        .sum  (add_sum),
        .ovf  (add_ovf_unused)
    );

    // Early exit looks at the multiplier after this cycle's shift.
    assign last_step = (cnt_q == CNT_LAST) ||
                       (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = add_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = acc_q;

endmodule

// File: tb/tb_mul64_seq.sv
// Bench for mul64_seq: two instances (early exit on/off) share stimulus and are
// checked against plain a*b and a latency rule derived from the multiplier's msb.
module tb_mul64_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy0, done0, busy1, done1;
    logic [63:0] result0, result1;

    int tests;
    int fails;

    mul64_seq #(.EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(result0)
    );

    mul64_seq #(.EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of RUN cycles an operation takes.
    function automatic int ref_lat(input logic [63:0] bv, input bit ee);
        if (!ee) return 64;
        for (int i = 63; i >= 0; i--) begin
            if (bv[i]) return i + 1;
        end
        return 1;
    endfunction

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy0 && !busy1) begin
                idle = 1'b1;
                break;
            end
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("FAIL %s idle timeout: busy0=%0b busy1=%0b want 0 0", tag, busy0, busy1);
        end
    endtask

    // Runs one operation on both DUTs; optionally pokes start at cycle 'poke'.
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input int poke,
                          input string tag);
        logic [63:0] exp;
        int lat0, got0, got1;
        exp  = av * bv;
        lat0 = ref_lat(bv, 1'b1);
        got0 = 0;
        got1 = 0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) @(negedge clk);
            start = 1'b0;
            if (c == poke) begin
                start = 1'b1;
                a = ~av;
                b = bv ^ 64'h5;
            end
            if (done0 && got0 == 0) begin
                got0 = c;
                tests++;
                if (result0 !== exp) begin
                    fails++;
                    $display("FAIL %s result_ee: got %h want %h", tag, result0, exp);
                end
            end
            if (done1 && got1 == 0) begin
                got1 = c;
                tests++;
                if (result1 !== exp) begin
                    fails++;
                    $display("FAIL %s result_full: got %h want %h", tag, result1, exp);
                end
            end
            if (got0 != 0 && got1 != 0) break;
        end
        start = 1'b0;
        tests++;
        if (got0 != lat0 + 1) begin
            fails++;
            $display("FAIL %s done_cycle_ee: got %0d want %0d", tag, got0, lat0 + 1);
        end
        tests++;
        if (got1 != 65) begin
            fails++;
            $display("FAIL %s done_cycle_full: got %0d want 65", tag, got1);
        end
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 ||
            result0 !== exp || result1 !== exp) begin
            fails++;
            $display("FAIL %s idle_hold: busy=%0b%0b done=%0b%0b res=%h/%h want 00 00 %h",
                     tag, busy0, busy1, done0, done1, result0, result1, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 64'd0 ||
            busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 64'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%0b%0b done=%0b%0b res=%h/%h want all zero",
                     busy0, busy1, done0, done1, result0, result1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(64'd3, 64'd5, 0, "a3_b5");
        run_op(-64'sd2, 64'd7, 0, "neg2_b7");
        run_op(64'h1234, 64'd0, 0, "b_zero");
        run_op(64'd1, 64'h8000_0000_0000_0000, 0, "b_msb");
        run_op(64'hDEAD_BEEF_0BAD_F00D, 64'd1, 0, "b_one");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "all_ones");
    endtask

    task automatic test_start_during_run();
        run_op(64'h0123_4567_89AB_CDEF, 64'h8765_4321_0FED_CBA9, 10, "start_in_run");
    endtask

    task automatic test_start_in_done();
        @(negedge clk);
        a = 64'd9; b = 64'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (done0 !== 1'b1) begin
            fails++;
            $display("FAIL start_in_done pulse: done=%0b want 1", done0);
        end
        a = 64'd100; b = 64'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 64'd45) begin
            fails++;
            $display("FAIL start_in_done ignored: busy=%0b done=%0b res=%0d want 0 0 45",
                     busy0, done0, result0);
        end
        wait_idle("start_in_done");
    endtask

    task automatic test_flush();
        bit saw_done;
        @(negedge clk);
        a = 64'd77; b = 64'hC000_0000_0000_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        tests++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 ||
            result0 !== 64'd0 || result1 !== 64'd0) begin
            fails++;
            $display("FAIL flush_idle: busy=%0b%0b done=%0b%0b res=%h/%h want all zero",
                     busy0, busy1, done0, done1, result0, result1);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done0 || done1 || busy0 || busy1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL flush_no_done: activity=1 want 0");
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 64'd12345; b = 64'hF000_0000_0000_0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 ||
            result0 !== 64'd0 || result1 !== 64'd0) begin
            fails++;
            $display("FAIL reset_mid_run: busy=%0b%0b done=%0b%0b res=%h/%h want all zero",
                     busy0, busy1, done0, done1, result0, result1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'd6, 64'd11, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [63:0] av, bv;
        for (int i = 0; i < 1000; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_op(av, bv, 0, "random");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_start_during_run();
        test_start_in_done();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
